truth_table_sampler: RTL and testbench
======================================

TRUTH_TABLE_SAMPLER -- requirements
Module: truth_table_sampler

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles to wait after applying each input vector before sampling; legal values 2 to 255.
REQ-002 SHALL have parameter NUM_SAMPLES, default 8: consecutive samples taken per vector; legal values 1 to 255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a full 16-vector characterisation run.
REQ-006 SHALL have port circ_in, output, 4 bits: input vector driven to the circuit under test.
REQ-007 SHALL have port circ_out, input, 1 bit: circuit-under-test output; asynchronous and possibly oscillating.
REQ-008 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking run completion.
REQ-010 SHALL have port truth_table, output, 16 bits: bit v holds the majority output value for vector v.
REQ-011 SHALL have port unstable, output, 16 bits: bit v is set when the samples for vector v disagreed.

Function
REQ-012 SHALL pass circ_out through a 2-flop synchroniser before any use; this latency is absorbed in the SETTLE wait.
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE, NEXT and DONE.
REQ-014 In IDLE, start=1 SHALL clear truth_table and unstable, set circ_in=0 and busy=1, and enter SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles with circ_in held, then enter SAMPLE.
REQ-016 SAMPLE SHALL last exactly NUM_SAMPLES cycles, counting synchronised ones (counter width of 8 bits or more) and tracking any disagreement.
REQ-017 At the end of SAMPLE, the block SHALL set truth_table[v] = (2*ones > NUM_SAMPLES), with ties giving 0.
REQ-018 At the end of SAMPLE, the block SHALL set unstable[v] = (ones != 0 and ones != NUM_SAMPLES).
REQ-019 NEXT SHALL take one cycle: if v<15, it increments circ_in (no wrap) and returns to SETTLE; if v=15, it enters DONE.
REQ-020 DONE SHALL last one cycle with done=1 and busy=0 asserted together, then return to IDLE with circ_in=0.
REQ-021 start SHALL be ignored outside IDLE; no restart and no queuing.
REQ-022 start sampled in DONE SHALL be ignored; start sampled in the following IDLE cycle SHALL begin a new run.
REQ-023 The done pulse SHALL occur exactly 16*(SETTLE_CYCLES+NUM_SAMPLES+1)+1 cycles after the cycle in which start was accepted.
REQ-024 truth_table and unstable SHALL hold their values from DONE until the next accepted start; bits for vectors not yet completed SHALL read 0 during a run.
REQ-025 circ_in SHALL change only on NEXT transitions or on reset.

Reset
REQ-026 rst=1 SHALL, at the next clk edge, force: state IDLE, circ_in=0, busy=0, done=0, truth_table=0, unstable=0, counters=0, synchroniser flops=0.
REQ-027 Reset mid-run SHALL abort the run with no done pulse; rst has priority over start in the same cycle.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the default SETTLE_CYCLES and NUM_SAMPLES constants, and the vector count constant (16).
REQ-029 The 2-flop synchroniser SHALL be the sub-module bit_synchronizer (1-bit, clk/rst), reusable by other circuit-test harnesses.
REQ-030 No latches, no combinational loops, and no asynchronous logic other than the synchroniser input are permitted.

Verification
REQ-031 Scenario 1: circ_out modelled as circ_in[0]&circ_in[1] with defaults, pulse start -> done after exactly 16*25+1=401 cycles, truth_table=16'h8888, unstable=16'h0000.
REQ-032 Scenario 2: circ_out tied to 1 -> truth_table=16'hFFFF, unstable=0; circ_out tied to 0 -> both 0.
REQ-033 Scenario 3: circ_out toggling every clk, NUM_SAMPLES=8 -> ones=4 (tie), so truth_table=16'h0000 and unstable=16'hFFFF.
REQ-034 Scenario 4: start re-asserted every cycle during a run -> exactly one done pulse at cycle 401; a new run starts only from the IDLE cycle after done.
REQ-035 Scenario 5: rst asserted while circ_in=5 -> next cycle busy=0, circ_in=0, truth_table=0, unstable=0, no done; a subsequent start produces a full correct run.
REQ-036 Scenario 6: circ_out = circ_in[3] delayed by 10 cycles, SETTLE_CYCLES=12 -> truth_table=16'hFF00, unstable=0.

Source files
------------

// File: rtl/truth_table_sampler_pkg.sv
// Shared definitions for the truth-table characterisation harness:
// sequencer states, default timing constants and the vector space size.
package truth_table_sampler_pkg;

    // Default number of cycles to wait after applying a vector before sampling
    localparam int unsigned DEF_SETTLE_CYCLES = 16;

    // Default number of consecutive samples taken per vector
    localparam int unsigned DEF_NUM_SAMPLES = 8;

    // The circuit under test has a 4-bit input, giving 16 vectors
    localparam int unsigned VEC_W = 4;
    localparam int unsigned NUM_VECTORS = 16;

    // Width of the settle/sample counters and of the ones counter
    localparam int unsigned CNT_W = 8;

    // Run sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for a single asynchronous bit. Both flops clear
// on the synchronous reset so the output is a known 0 after reset.
module bit_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/truth_table_sampler.sv
// Truth-table sampler: steps a 4-bit input vector through all 16 values,
// waits for the circuit under test to settle, takes a burst of samples of
// its (synchronised) output, and records a majority value plus an
// "outputs disagreed" flag for every vector.
module truth_table_sampler
    import truth_table_sampler_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned NUM_SAMPLES   = DEF_NUM_SAMPLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [VEC_W-1:0]       circ_in,
    input  logic                   circ_out,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] truth_table,
    output logic [NUM_VECTORS-1:0] unstable
);

    // Terminal counts, sized to the counters they are compared against
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] SAMPLES_W   = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W:0]   SAMPLES_W1  = (CNT_W + 1)'(NUM_SAMPLES);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    // Majority vote: strictly more than half the samples were 1; a tie is 0
    function automatic logic majority(input logic [CNT_W-1:0] ones);
        return ({ones, 1'b0} > SAMPLES_W1);
    endfunction

    // Samples disagreed when they were neither all 0 nor all 1
    function automatic logic disagreed(input logic [CNT_W-1:0] ones);
        return (ones != '0) && (ones != SAMPLES_W);
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_ones;
    logic [VEC_W-1:0]        r_circ_in;
    logic [NUM_VECTORS-1:0]  r_tt;
    logic [NUM_VECTORS-1:0]  r_un;

    logic                    w_sync;
    logic                    w_settle_last;
    logic                    w_sample_last;
    logic                    w_last_vec;
    logic [CNT_W-1:0]        w_ones_total;
    logic                    w_busy;
    logic                    w_done;

    bit_synchronizer u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (circ_out),
        .o_q (w_sync)
    );

    assign w_settle_last = (r_cnt == SETTLE_LAST);
    assign w_sample_last = (r_cnt == SAMPLE_LAST);
    assign w_last_vec    = (r_circ_in == LAST_VEC);

    // Ones count including the sample taken in the current cycle
    assign w_ones_total  = r_ones + {{(CNT_W-1){1'b0}}, w_sync};

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next-state and status outputs; start only counts in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                w_busy = 1'b1;
                if (w_settle_last) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_busy = 1'b1;
                if (w_sample_last) begin
                    w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                w_busy      = 1'b1;
                w_state_nxt = w_last_vec ? DONE : SETTLE;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Phase counter, ones counter and applied vector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ones    <= '0;
            r_circ_in <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_ones    <= '0;
                        r_circ_in <= '0;
                    end
                end
                SETTLE: begin
                    r_cnt <= w_settle_last ? '0 : r_cnt + 1'b1;
                end
                SAMPLE: begin
                    if (w_sample_last) begin
                        r_cnt  <= '0;
                        r_ones <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_ones <= w_ones_total;
                    end
                end
                NEXT: begin
                    if (!w_last_vec) begin
                        r_circ_in <= r_circ_in + 1'b1;
                    end
                end
                DONE: begin
                    r_circ_in <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Result tables: cleared on an accepted start, one bit written per vector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tt <= '0;
            r_un <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_tt <= '0;
            r_un <= '0;
        end else if ((r_state == SAMPLE) && w_sample_last) begin
            r_tt[r_circ_in] <= majority(w_ones_total);
            r_un[r_circ_in] <= disagreed(w_ones_total);
        end
    end

    assign circ_in     = r_circ_in;
    assign busy        = w_busy;
    assign done        = w_done;
    assign truth_table = r_tt;
    assign unstable    = r_un;

endmodule

// File: tb/tb_truth_table_sampler.sv
// Scoreboard bench for truth_table_sampler: stimulus pushes the expected
// completion (cycle, truth table, unstable mask) into a queue, a monitor
// pops and compares whenever a done pulse appears.
module tb_truth_table_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start6 = 1'b0;
    logic [3:0]  circ_in, circ_in6;
    logic        circ_out, circ_out6;
    logic        busy, busy6, done, done6;
    logic [15:0] tt, un, tt6, un6;

    int          mode = 0;
    logic        tog = 1'b0;
    logic [9:0]  dly = '0;
    int unsigned cyc = 0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_spurious = 0;

    typedef struct {
        int unsigned cyc;
        logic [15:0] tt;
        logic [15:0] un;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t q6[$];

    always #5 clk = ~clk;

    // Cycle counter, toggling source and 10-cycle delay line
    always @(posedge clk) begin
        cyc <= cyc + 1;
        tog <= ~tog;
        dly <= {dly[8:0], circ_in6[3]};
    end

    // Circuit-under-test models for the default-parameter instance
    always_comb begin
        case (mode)
            0:       circ_out = circ_in[0] & circ_in[1];
            1:       circ_out = 1'b1;
            2:       circ_out = 1'b0;
            default: circ_out = tog;
        endcase
    end

    assign circ_out6 = dly[9];

    truth_table_sampler u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .circ_in     (circ_in),
        .circ_out    (circ_out),
        .busy        (busy),
        .done        (done),
        .truth_table (tt),
        .unstable    (un)
    );

    truth_table_sampler #(
        .SETTLE_CYCLES (12),
        .NUM_SAMPLES   (8)
    ) u_dut6 (
        .clk         (clk),
        .rst         (rst),
        .start       (start6),
        .circ_in     (circ_in6),
        .circ_out    (circ_out6),
        .busy        (busy6),
        .done        (done6),
        .truth_table (tt6),
        .unstable    (un6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsz(input int which);
        return (which == 0) ? q.size() : q6.size();
    endfunction

    task automatic wait_drain(input int which, input int budget);
        int i = 0;
        while (qsz(which) != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (qsz(which) != 0) begin
            chk("drain_timeout", qsz(which), 0);
            if (which == 0) q.delete();
            else q6.delete();
        end
    endtask

    task automatic run(input int m, input logic [15:0] ett, input logic [15:0] eun, input string nm);
        exp_t e;
        @(negedge clk);
        mode   = m;
        start  = 1'b1;
        e.cyc  = cyc + 401;
        e.tt   = ett;
        e.un   = eun;
        e.name = nm;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_drain(0, 500);
    endtask

    // Monitor: compare every done pulse against the head of its queue
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    n_spurious++;
                end else begin
                    e = q.pop_front();
                    chk($sformatf("%s_done_cycle", e.name), cyc, e.cyc);
                    chk($sformatf("%s_truth_table", e.name), tt, e.tt);
                    chk($sformatf("%s_unstable", e.name), un, e.un);
                    chk($sformatf("%s_busy_at_done", e.name), busy, 0);
                end
            end
            if (done6) begin
                if (q6.size() == 0) begin
                    n_spurious++;
                end else begin
                    e = q6.pop_front();
                    chk($sformatf("%s_done_cycle", e.name), cyc, e.cyc);
                    chk($sformatf("%s_truth_table", e.name), tt6, e.tt);
                    chk($sformatf("%s_unstable", e.name), un6, e.un);
                    chk($sformatf("%s_busy_at_done", e.name), busy6, 0);
                end
            end
        end
    end

    // Stimulus
    initial begin : stim
        exp_t        e;
        int unsigned k;
        int          i;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_circ_in", circ_in, 0);
        chk("rst_truth_table", tt, 0);
        chk("rst_unstable", un, 0);
        rst = 1'b0;

        run(0, 16'h8888, 16'h0000, "and2");
        run(1, 16'hFFFF, 16'h0000, "tied1");
        run(2, 16'h0000, 16'h0000, "tied0");
        run(3, 16'h0000, 16'hFFFF, "toggle");

        // start held high through a whole run: one done, restart after DONE
        @(negedge clk);
        mode   = 0;
        start  = 1'b1;
        k      = cyc;
        e.cyc  = k + 401;
        e.tt   = 16'h8888;
        e.un   = 16'h0000;
        e.name = "held_start_run1";
        q.push_back(e);
        e.cyc  = k + 803;
        e.name = "held_start_run2";
        q.push_back(e);
        repeat (401) @(negedge clk);
        chk("held_busy_in_done", busy, 0);
        @(negedge clk);
        chk("held_busy_in_idle", busy, 0);
        chk("held_done_in_idle", done, 0);
        @(negedge clk);
        chk("held_restart_busy", busy, 1);
        start = 1'b0;
        wait_drain(0, 900);

        // Reset part way through a run
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (circ_in != 4'd5 && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("midrun_reached_vec5", circ_in, 5);
        chk("midrun_partial_truth_table", tt, 16'h0008);
        chk("midrun_partial_unstable", un, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_circ_in", circ_in, 0);
        chk("abort_truth_table", tt, 0);
        chk("abort_unstable", un, 0);
        repeat (450) @(negedge clk);
        chk("abort_no_done_busy", busy, 0);
        run(0, 16'h8888, 16'h0000, "after_abort");

        // Delayed circuit on the SETTLE_CYCLES=12 instance
        @(negedge clk);
        start6 = 1'b1;
        e.cyc  = cyc + 16 * (12 + 8 + 1) + 1;
        e.tt   = 16'hFF00;
        e.un   = 16'h0000;
        e.name = "delay10";
        q6.push_back(e);
        @(negedge clk);
        start6 = 1'b0;
        wait_drain(1, 500);

        repeat (5) @(negedge clk);
        chk("spurious_done_count", n_spurious, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
